// File: rtl/add_mul_iter.sv
// Iterative carry-save adder-multiplier: P = (XS+XC)*Y + A.
// Retires `digits` multiplier bits per cycle over N iterations.
module add_mul_iter #(
  parameter int widthX = 8,
  parameter int widthY = 8,
  parameter int digits = 2,
  localparam int widthP = widthX + widthY + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [widthX-1:0] XS,
  input  logic [widthX-1:0] XC,
  input  logic [widthY-1:0] Y,
  input  logic              acc_en_i,
  input  logic [widthP-1:0] A,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [widthP-1:0] P
);

  localparam int WM = widthX + 1;
  localparam int N  = (WM + digits - 1) / digits;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (widthX < 1 || widthY < widthX) begin : g_bad_width
    $error("add_mul_iter: illegal widthX/widthY");
  end

  if (digits < 1 || digits > WM) begin : g_bad_digits
    $error("add_mul_iter: digits out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q;
  logic [WM-1:0]     m_q;
  logic [widthY-1:0] y_q;
  logic [widthP-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic              rdy_q;
  logic              vld_q;

  logic [WM-1:0]     sum_d;
  logic [widthP-1:0] pp_d;
  logic [widthP-1:0] acc_d;

  // Exact M sum and the shifted partial product for this iteration
  always_comb begin
    sum_d = WM'(XS) + WM'(XC);
    pp_d  = widthP'(m_q[digits-1:0]) * widthP'(y_q);
    pp_d  = pp_d << (32'(cnt_q) * digits);
    acc_d = acc_q + pp_d;
  end

  // Control FSM and datapath registers with registered handshake flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            m_q     <= sum_d;
            y_q     <= Y;
            acc_q   <= acc_en_i ? A : '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          m_q   <= m_q >> digits;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = vld_q;
  assign P           = acc_q;

endmodule

// File: tb/tb_add_mul_iter.sv
// Scoreboard bench for add_mul_iter over digits = 2, 1, 3, 9.
// Directed cases on the digits=2 instance, random sweep on all.
module tb_add_mul_iter;

  localparam int NK = 4;
  localparam int DG[NK] = '{2, 1, 3, 9};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv[NK];
  logic        ir[NK];
  logic [7:0]  xs[NK];
  logic [7:0]  xc[NK];
  logic [7:0]  y[NK];
  logic        ae[NK];
  logic [16:0] a[NK];
  logic        ov[NK];
  logic        ordy[NK];
  logic [16:0] p[NK];

  logic [16:0] expq[NK][$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit go = 0;
  int ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] model(logic [7:0] s, logic [7:0] c,
                                        logic [7:0] yy, logic e,
                                        logic [16:0] aa);
    longint m;
    longint r;
    m = longint'(s) + longint'(c);
    r = m * longint'(yy) + (e ? longint'(aa) : 64'd0);
    return 17'(r % 131072);
  endfunction

  task automatic chk(string nm, int k, longint got, longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, k, got, exp);
    end
  endtask

  task automatic bad(string nm, int k);
    vectors++;
    miscompares++;
    $display("FAIL %s dut%0d: timeout/unexpected", nm, k);
  endtask

  // Present operands, hold until accepted, then push expected result
  task automatic issue(int k, logic [7:0] s, logic [7:0] c,
                       logic [7:0] yy, logic e, logic [16:0] aa);
    bit ok;
    xs[k] = s;
    xc[k] = c;
    y[k]  = yy;
    ae[k] = e;
    a[k]  = aa;
    iv[k] = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ir[k]) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    xs[k] = 8'($urandom);
    xc[k] = 8'($urandom);
    y[k]  = 8'($urandom);
    a[k]  = 17'($urandom);
    ae[k] = 1'($urandom);
    if (ok) expq[k].push_back(model(s, c, yy, e, aa));
    else bad("accept", k);
  endtask

  task automatic wait_ov(int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ov[k]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bad("out_valid", k);
  endtask

  for (genvar gk = 0; gk < NK; gk++) begin : g_dut
    localparam int K = gk;
    localparam int NN = (9 + DG[gk] - 1) / DG[gk];

    add_mul_iter #(
      .widthX(8),
      .widthY(8),
      .digits(DG[gk])
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (iv[gk]),
      .in_ready_o (ir[gk]),
      .XS         (xs[gk]),
      .XC         (xc[gk]),
      .Y          (y[gk]),
      .acc_en_i   (ae[gk]),
      .A          (a[gk]),
      .out_valid_o(ov[gk]),
      .out_ready_i(ordy[gk]),
      .P          (p[gk])
    );

    int          acc_c;
    logic        pv;
    logic        pr;
    logic [16:0] ph;

    // Monitor: latency, hold-stability and scoreboard pop
    always @(negedge clk) begin
      if (!rst_n) begin
        pv <= 1'b0;
        pr <= 1'b1;
      end else begin
        if (iv[K] && ir[K]) acc_c <= cyc;
        if (ov[K] && !pv) chk("latency", K, cyc - acc_c, NN + 1);
        if (ov[K] && pv && !pr) chk("P_hold", K, p[K], ph);
        if (ov[K] && ordy[K]) begin
          if (expq[K].size() == 0) bad("unexpected_out", K);
          else chk("P", K, p[K], expq[K].pop_front());
        end
        pv <= ov[K];
        pr <= ordy[K];
        ph <= p[K];
      end
    end

    initial begin
      wait (go);
      for (int i = 0; i < 30; i++) begin
        issue(K, 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 17'($urandom));
      end
      ndone++;
    end

    initial begin
      wait (go);
      forever begin
        @(posedge clk);
        #1;
        ordy[K] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic [16:0] held;
    bit ok;
    rst_n = 1'b0;
    for (int k = 0; k < NK; k++) begin
      iv[k] = 0; xs[k] = 0; xc[k] = 0; y[k] = 0;
      ae[k] = 0; a[k] = 0; ordy[k] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk("rst_ready", k, ir[k], 1);
      chk("rst_valid", k, ov[k], 0);
      chk("rst_P", k, p[k], 0);
    end
    @(posedge clk);
    #1;

    issue(0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 17'h0);
    wait_ov(0);
    chk("full_scale", 0, p[0], 17'h1FC02);
    @(posedge clk);
    #1;

    issue(0, 8'd3, 8'd4, 8'd5, 1'b1, 17'h1FFFF);
    wait_ov(0);
    chk("acc_wrap", 0, p[0], 17'h00022);
    @(posedge clk);
    #1;

    ordy[0] = 1'b0;
    issue(0, 8'h12, 8'h34, 8'h56, 1'b0, 17'h0);
    wait_ov(0);
    held = p[0];
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 0, ov[0], 1);
      chk("bp_ready", 0, ir[0], 0);
      chk("bp_P", 0, p[0], held);
      @(posedge clk);
      #1;
      if (i == 0) begin
        xs[0] = 8'h9A; xc[0] = 8'hBC; y[0] = 8'hDE;
        ae[0] = 1'b1; a[0] = 17'h01234;
        iv[0] = 1'b1;
      end
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready", 0, ir[0], 0);
    chk("bp_hs_valid", 0, ov[0], 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_after_ready", 0, ir[0], 1);
    chk("bp_after_valid", 0, ov[0], 0);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    expq[0].push_back(model(8'h9A, 8'hBC, 8'hDE, 1'b1, 17'h01234));
    wait_ov(0);
    @(posedge clk);
    #1;

    issue(0, 8'h55, 8'h22, 8'h77, 1'b0, 17'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq[0].delete();
    @(negedge clk);
    chk("midrst_valid", 0, ov[0], 0);
    chk("midrst_ready", 0, ir[0], 1);
    chk("midrst_P", 0, p[0], 0);
    @(posedge clk);
    #1;
    issue(0, 8'd1, 8'd0, 8'd7, 1'b0, 17'h0);
    wait_ov(0);
    chk("fresh_op", 0, p[0], 17'd7);
    @(posedge clk);
    #1;

    go = 1;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (ndone == NK) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bad("sweep_done", 0);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (expq[0].size() == 0 && expq[1].size() == 0 &&
          expq[2].size() == 0 && expq[3].size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bad("drain", 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_mul_iter.md
# add_mul_iter

Iterative, handshaked adder-multiplier for unsigned operands. It computes P = (XS+XC)*Y + acc. The multiplier arrives in carry-save form as XS and XC, and the accumulate term is optional. It is the sequential successor to the combinational carry-save adder-multiplier in the arithmetic library. It trades area for latency by retiring `digits` multiplier bits per cycle, and it widens the result by one bit so that an overflowing XS+XC sum is still exact. It sits between a carry-save datapath producer and any valid/ready consumer, for example a MAC or filter stage.

## Interface
- `widthX`, 8, word width of XS and XC. Must be ≥ 1.
- `widthY`, 8, word width of Y. Must be ≥ widthX.
- `digits`, 2, multiplier bits retired per cycle. Legal range 1..widthX+1; any other value is an elaboration error.
- Derived: `widthP` = widthX+widthY+1; `N` = ceil((widthX+1)/digits), the number of iterations.
- One clock. Reset is synchronous and active-low.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  synchronous active-low reset.
- `in_valid_i`  in  1  operand set valid.
- `in_ready_o`  out  1  block can accept operands.
- `XS`  in  widthX  multiplier, sum part.
- `XC`  in  widthX  multiplier, carry part.
- `Y`  in  widthY  multiplicand.
- `acc_en_i`  in  1  add `A` into the result.
- `A`  in  widthP  accumulate operand. Ignored when acc_en_i=0.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `P`  out  widthP  result.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE:**
  - in_ready_o=1 and out_valid_o=0.
  - On in_valid_i & in_ready_o, the block registers M = XS+XC (widthX+1 bits, exact) and Y.
  - The accumulator is initialised to A if acc_en_i=1, otherwise to 0.
  - The iteration counter is set to 0 and the FSM moves to BUSY.
  - Inputs are not sampled at any other time.
- **BUSY:**
  - Each cycle, acc += (M[digits-1:0] * Y) << (counter*digits).
  - M then shifts right by digits, and the counter increments.
  - After iteration N-1 the FSM moves to DONE.
  - in_ready_o=0 and out_valid_o=0.
- **DONE:**
  - out_valid_o=1 and P = acc.
  - P is held stable while out_ready_i=0.
  - On out_valid_o & out_ready_i, the FSM moves to IDLE.
  - in_ready_o=0 in DONE. There is no overlap of result drain and operand accept.
- **Arithmetic:**
  - Unsigned only. All accumulation is modulo 2^widthP.
  - Without acc_en_i the result is always exact, since (2^(widthX+1)-2)*(2^widthY-1) < 2^widthP.
  - With acc_en_i the result wraps modulo 2^widthP and no overflow flag is produced.
- **Partial slice:** when digits does not divide widthX+1, the final iteration sees zero-filled upper bits of M. The result is unaffected.
- **Reset** (rst_ni=0 at a rising edge), from any state including mid-BUSY:
  - The FSM returns to IDLE and any in-flight operation is discarded.
  - out_valid_o=0, in_ready_o=1 on the first cycle after reset, P=0, accumulator=0, counter=0.
- in_valid_i asserted during BUSY or DONE has no effect. The producer must hold its operands until it sees in_ready_o.
- X/Z on the operand inputs while no handshake is occurring must not propagate into state.

## Timing
- Accept handshake at the edge ending cycle c0. BUSY occupies cycles c1..cN. DONE starts in cycle cN+1.
- Latency from accept to out_valid_o is N+1 cycles.
- With out_ready_i held high, the output handshake happens at the end of cycle cN+1. IDLE and in_ready_o=1 follow in cycle cN+2.
- Initiation interval is N+2 cycles.
- digits=widthX+1 gives N=1: a single BUSY cycle, latency 2.
- All outputs are driven directly from registers or state decode. There is no combinational path from any input to any output.

## Test plan
- **Reset values:** hold rst_ni=0 for 2 cycles, then release. Required: in_ready_o=1, out_valid_o=0, P=0.
- **Full-scale:** widthX=widthY=8, digits=2 (N=5), XS=XC=Y=0xFF, acc_en_i=0. Required: out_valid_o rises exactly 6 cycles after accept, with P=0x1FC02 (510*255).
- **Accumulate wrap:** XS=3, XC=4, Y=5, acc_en_i=1, A=0x1FFFF. Required: P=0x00022 (35+131071 mod 2^17).
- **Backpressure:** hold out_ready_i=0 for 4 cycles in DONE, with in_valid_i=1 and new operands present. Required: P stable, out_valid_o=1, in_ready_o=0, and the new operands are not accepted until the cycle after the output handshake.
- **Reset mid-operation:** assert rst_ni=0 during BUSY cycle c3. Required: next cycle is IDLE with P=0 and out_valid_o=0, and a fresh op (XS=1, XC=0, Y=7) then yields P=7.
- **Randomized sweep:** digits ∈ {1, 3, 9} with random XS, XC, Y, A, acc_en_i and random out_ready_i stalls. Required: P matches ((XS+XC)*Y + acc_en_i*A) mod 2^17, and every latency equals N+1.
